// File: rtl/exception_ctrl.sv
// Exception arbitration and redirect unit at the MEM/WB boundary.
// Picks the highest-priority exception, reports it to CP0, and issues a one-cycle flush.
module exception_ctrl #(
    parameter logic [31:0] EXC_VEC_BEV1 = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC_BEV0 = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallW,
    input  logic [5:0]  ext_int,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        is_in_delayslot_m,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        sys,
    input  logic        bp,
    input  logic        ov,
    input  logic        adel_mem,
    input  logic        ades_mem,
    input  logic        eret,
    input  logic [31:0] data_vaddr_m,
    output logic        en_o,
    output logic [31:0] except_type_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    typedef enum logic {StIdle, StFlush} state_e;

    localparam logic [31:0] TypeNone = 32'h0;
    localparam logic [31:0] TypeInt  = 32'h1;
    localparam logic [31:0] TypeAdel = 32'h4;
    localparam logic [31:0] TypeAdes = 32'h5;
    localparam logic [31:0] TypeSys  = 32'h8;
    localparam logic [31:0] TypeBp   = 32'h9;
    localparam logic [31:0] TypeRi   = 32'hA;
    localparam logic [31:0] TypeOv   = 32'hC;
    localparam logic [31:0] TypeEret = 32'hE;

    state_e      r_state;
    logic [5:0]  r_sync1;
    logic [5:0]  r_hw_sync;
    logic        r_flush;
    logic [31:0] r_newpc;

    logic [7:0]  w_pend;
    logic        w_int_req;
    logic        w_any_flag;
    logic        w_commit;
    logic [31:0] w_type;
    logic [31:0] w_badvaddr;
    logic [31:0] w_newpc;

    assign w_pend = {r_hw_sync | cause_i[15:10], cause_i[9:8]} & status_i[15:8];
    assign w_int_req = (|w_pend) & status_i[0] & ~status_i[1] & valid_m;
    assign w_any_flag = valid_m & (adel_if | ri | sys | bp | ov | adel_mem | ades_mem | eret);

    // en_o is qualified by resetn so nothing reaches CP0 while reset is held.
    assign w_commit = resetn & (r_state == StIdle) & ~stallW & (w_any_flag | w_int_req);

    always_comb begin
        w_type     = TypeNone;
        w_badvaddr = 32'h0;
        if (w_int_req) begin
            w_type = TypeInt;
        end else if (valid_m) begin
            if (adel_if) begin
                w_type     = TypeAdel;
                w_badvaddr = pc_m;
            end else if (ri) begin
                w_type = TypeRi;
            end else if (sys) begin
                w_type = TypeSys;
            end else if (bp) begin
                w_type = TypeBp;
            end else if (ov) begin
                w_type = TypeOv;
            end else if (adel_mem) begin
                w_type     = TypeAdel;
                w_badvaddr = data_vaddr_m;
            end else if (ades_mem) begin
                w_type     = TypeAdes;
                w_badvaddr = data_vaddr_m;
            end else if (eret) begin
                w_type = TypeEret;
            end
        end
    end

    always_comb begin
        w_newpc = status_i[22] ? EXC_VEC_BEV1 : EXC_VEC_BEV0;
        if (w_type == TypeEret) begin
            w_newpc = epc_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= 6'h0;
            r_hw_sync <= 6'h0;
        end else begin
            r_sync1   <= ext_int;
            r_hw_sync <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_flush <= 1'b0;
            r_newpc <= 32'h0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_commit) begin
                        r_state <= StFlush;
                        r_flush <= 1'b1;
                        r_newpc <= w_newpc;
                    end else begin
                        r_flush <= 1'b0;
                    end
                end
                StFlush: begin
                    r_state <= StIdle;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign en_o                = w_commit;
    assign except_type_o       = w_commit ? w_type : TypeNone;
    assign badvaddr_o          = w_commit ? w_badvaddr : 32'h0;
    assign current_inst_addr_o = pc_m;
    assign is_in_delayslot_o   = is_in_delayslot_m;
    assign flush_o             = r_flush;
    assign newpc_o             = r_newpc;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: reset, priority, interrupt, stall, ERET and flush timing.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallW;
    logic [5:0]  ext_int;
    logic [31:0] status_i, cause_i, epc_i;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        is_in_delayslot_m;
    logic        adel_if, ri, sys, bp, ov, adel_mem, ades_mem, eret;
    logic [31:0] data_vaddr_m;
    logic        en_o;
    logic [31:0] except_type_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic [31:0] newpc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk                 (clk),
        .resetn              (resetn),
        .stallW              (stallW),
        .ext_int             (ext_int),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .valid_m             (valid_m),
        .pc_m                (pc_m),
        .is_in_delayslot_m   (is_in_delayslot_m),
        .adel_if             (adel_if),
        .ri                  (ri),
        .sys                 (sys),
        .bp                  (bp),
        .ov                  (ov),
        .adel_mem            (adel_mem),
        .ades_mem            (ades_mem),
        .eret                (eret),
        .data_vaddr_m        (data_vaddr_m),
        .en_o                (en_o),
        .except_type_o       (except_type_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .badvaddr_o          (badvaddr_o),
        .flush_o             (flush_o),
        .newpc_o             (newpc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0; stallW = 1'b0; ext_int = 6'h0;
        status_i = 32'h0040_0000; cause_i = 32'h0; epc_i = 32'h0;
        valid_m = 1'b1; pc_m = 32'hBFC0_0100; is_in_delayslot_m = 1'b0;
        adel_if = 0; ri = 0; sys = 1; bp = 0; ov = 0; adel_mem = 0; ades_mem = 0; eret = 0;
        data_vaddr_m = 32'h0;

        // Reset held with a flag present: nothing reported
        tick(); tick();
        chk("rst_en", {31'h0, en_o}, 32'h0);
        chk("rst_type", except_type_o, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_newpc", newpc_o, 32'h0);
        sys = 0;
        tick();
        resetn = 1'b1;
        tick(); settle();
        chk("idle_en", {31'h0, en_o}, 32'h0);
        chk("idle_flush", {31'h0, flush_o}, 32'h0);

        // SYS with BEV=1
        sys = 1; settle();
        chk("sys_en", {31'h0, en_o}, 32'h1);
        chk("sys_type", except_type_o, 32'h8);
        chk("sys_pc", current_inst_addr_o, 32'hBFC0_0100);
        chk("sys_ds", {31'h0, is_in_delayslot_o}, 32'h0);
        tick(); settle();
        chk("sys_flush_en", {31'h0, en_o}, 32'h0);
        sys = 0; settle();
        chk("sys_flush", {31'h0, flush_o}, 32'h1);
        chk("sys_newpc", newpc_o, 32'hBFC0_0380);
        tick(); settle();
        chk("sys_flush_end", {31'h0, flush_o}, 32'h0);

        // Priority: OV beats ADES
        ov = 1; ades_mem = 1; data_vaddr_m = 32'h1003; is_in_delayslot_m = 1'b1; settle();
        chk("pri_ov_type", except_type_o, 32'hC);
        chk("pri_ov_bva", badvaddr_o, 32'h0);
        chk("pri_ds", {31'h0, is_in_delayslot_o}, 32'h1);
        tick(); ov = 0; settle();
        chk("pri_flush_en", {31'h0, en_o}, 32'h0);
        tick(); settle();
        chk("ades_type", except_type_o, 32'h5);
        chk("ades_bva", badvaddr_o, 32'h1003);
        // Fetch ADEL beats RI and reports pc_m
        ades_mem = 0; adel_if = 1; ri = 1; is_in_delayslot_m = 1'b0; settle();
        chk("adelif_type", except_type_o, 32'h4);
        chk("adelif_bva", badvaddr_o, 32'hBFC0_0100);
        adel_if = 0; adel_mem = 1; ri = 0; data_vaddr_m = 32'h2002; settle();
        chk("adelmem_type", except_type_o, 32'h4);
        chk("adelmem_bva", badvaddr_o, 32'h2002);
        tick(); adel_mem = 0;
        tick(); settle();
        chk("pri_idle", {31'h0, en_o}, 32'h0);

        // Interrupt via HW0 / IM2
        status_i = 32'h0040_0401; ext_int = 6'h01; settle();
        chk("int_e0", {31'h0, en_o}, 32'h0);
        tick(); settle();
        chk("int_e1", {31'h0, en_o}, 32'h0);
        tick(); settle();
        chk("int_en", {31'h0, en_o}, 32'h1);
        chk("int_type", except_type_o, 32'h1);
        chk("int_bva", badvaddr_o, 32'h0);
        status_i = 32'h0040_0403; settle();
        chk("int_exl", {31'h0, en_o}, 32'h0);
        status_i = 32'h0040_0401; valid_m = 1'b0; settle();
        chk("int_bubble", {31'h0, en_o}, 32'h0);
        valid_m = 1'b1; settle();
        chk("int_en2", {31'h0, en_o}, 32'h1);
        tick(); settle();
        chk("int_flush", {31'h0, flush_o}, 32'h1);
        chk("int_newpc", newpc_o, 32'hBFC0_0380);
        ext_int = 6'h0; status_i = 32'h0;
        tick(); tick(); tick(); settle();
        chk("int_gone", {31'h0, en_o}, 32'h0);

        // Stall holds detection; BEV=0 vector afterwards
        stallW = 1'b1; sys = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_en", {31'h0, en_o}, 32'h0);
            chk("stall_flush", {31'h0, flush_o}, 32'h0);
            tick();
        end
        stallW = 1'b0; settle();
        chk("unstall_en", {31'h0, en_o}, 32'h1);
        tick(); sys = 0; settle();
        chk("unstall_flush", {31'h0, flush_o}, 32'h1);
        chk("unstall_newpc", newpc_o, 32'h8000_0180);
        chk("unstall_en2", {31'h0, en_o}, 32'h0);
        tick(); settle();
        chk("unstall_end", {31'h0, flush_o}, 32'h0);

        // ERET redirects to EPC; RI during FLUSH ignored
        epc_i = 32'h8000_1234; eret = 1; settle();
        chk("eret_en", {31'h0, en_o}, 32'h1);
        chk("eret_type", except_type_o, 32'hE);
        tick(); eret = 0; ri = 1; epc_i = 32'h0; settle();
        chk("eret_flush", {31'h0, flush_o}, 32'h1);
        chk("eret_newpc", newpc_o, 32'h8000_1234);
        chk("eret_ri_en", {31'h0, en_o}, 32'h0);
        ri = 0;
        tick(); settle();
        chk("eret_after_en", {31'h0, en_o}, 32'h0);
        chk("eret_after_flush", {31'h0, flush_o}, 32'h0);

        // Reset asserted during FLUSH
        sys = 1; status_i = 32'h0040_0000; settle();
        tick(); sys = 0; settle();
        chk("rf_flush", {31'h0, flush_o}, 32'h1);
        resetn = 1'b0; settle();
        chk("rf_flush_drop", {31'h0, flush_o}, 32'h0);
        chk("rf_newpc", newpc_o, 32'h0);
        tick();
        resetn = 1'b1;
        tick(); settle();
        chk("rf_after_flush", {31'h0, flush_o}, 32'h0);
        chk("rf_after_en", {31'h0, en_o}, 32'h0);
        tick(); settle();
        chk("rf_after_flush2", {31'h0, flush_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
